// File: rtl/memory_dp_sync.sv
// Simple-dual-port synchronous RAM with byte enables, 1- or 2-cycle read latency,
// selectable read-during-write behaviour and a post-reset clear sweep.
module memory_dp_sync #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned RDW_MODE   = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    init_busy,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid
);

  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  typedef enum logic [0:0] {StClear, StReady} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0]   mem_q [Depth];

  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   wr_merged;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic                    rd_accept;

  logic                    s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0]   s1_data_q, s1_data_d;

  // Word as it will look after this cycle's write: enabled lanes new, others old.
  always_comb begin
    wr_merged = mem_q[wr_addr];
    for (int unsigned i = 0; i < NB; i++) begin
      if (wr_be[i]) wr_merged[8*i +: 8] = wr_data[8*i +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_merged;
    unique case (state_q)
      StClear: begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = INIT_VALUE;
        ptr_d     = ptr_q + ADDR_WIDTH'(1);
        if (ptr_q == {ADDR_WIDTH{1'b1}}) state_d = StReady;
      end
      StReady: begin
        mem_we = wr_en;
      end
      default: state_d = StClear;
    endcase
  end

  assign rd_accept = (state_q == StReady) && rd_en;

  always_comb begin
    rd_word = mem_q[rd_addr];
    if (RDW_MODE == 1 && wr_en && (wr_addr == rd_addr)) rd_word = wr_merged;
  end

  assign s1_valid_d = rd_accept;
  assign s1_data_d  = rd_accept ? rd_word : s1_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StClear;
      ptr_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
    end
  end

  // Storage has no reset; the clear sweep initialises it.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign init_busy = (state_q == StClear);

  if (RD_LATENCY == 2) begin : g_lat2
    logic                  s2_valid_q, s2_valid_d;
    logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;

    assign s2_valid_d = s1_valid_q;
    assign s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s2_valid_d;
        s2_data_q  <= s2_data_d;
      end
    end

    assign rd_valid = s2_valid_q;
    assign rd_data  = s2_data_q;
  end else begin : g_lat1
    assign rd_valid = s1_valid_q;
    assign rd_data  = s1_data_q;
  end

endmodule

// File: tb/tb_memory_dp_sync.sv
// Scoreboard bench: an 8-bit latency-1 old-data instance and a 32-bit latency-2
// new-data instance share one stimulus stream; each has its own expected queue.
module tb_memory_dp_sync;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [3:0]  wr_addr, rd_addr, wr_be;
  logic [31:0] wr_data;

  logic        busy_a, valid_a, busy_b, valid_b;
  logic [7:0]  data_a;
  logic [31:0] data_b;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] data;
    int          t;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  logic        rst_prev = 1'b0;
  logic        armed    = 1'b0;
  logic [7:0]  last_a   = '0;
  logic [31:0] last_b   = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_prev <= rst;
    armed    <= armed | rst;
  end

  memory_dp_sync #(
    .ADDR_WIDTH(4), .DATA_WIDTH(8), .RD_LATENCY(1), .RDW_MODE(0), .INIT_VALUE(8'h00)
  ) dut_a (
    .clk      (clk),
    .rst      (rst),
    .init_busy(busy_a),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_be    (wr_be[0:0]),
    .wr_data  (wr_data[7:0]),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (data_a),
    .rd_valid (valid_a)
  );

  memory_dp_sync #(
    .ADDR_WIDTH(4), .DATA_WIDTH(32), .RD_LATENCY(2), .RDW_MODE(1), .INIT_VALUE(32'h0)
  ) dut_b (
    .clk      (clk),
    .rst      (rst),
    .init_busy(busy_b),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_be    (wr_be),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (data_b),
    .rd_valid (valid_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops on every rd_valid; otherwise rd_data must hold.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (armed) begin
      if (rst_prev) begin
        check("a_rst_valid", {31'b0, valid_a}, 32'd0);
        check("a_rst_data", {24'b0, data_a}, 32'd0);
        check("b_rst_valid", {31'b0, valid_b}, 32'd0);
        check("b_rst_data", data_b, 32'd0);
        last_a = '0;
        last_b = '0;
      end else begin
        if (valid_a) begin
          if (qa.size() == 0) check("a_unexpected_valid", 32'd1, 32'd0);
          else begin
            e = qa.pop_front();
            check("a_data", {24'b0, data_a}, e.data);
            check("a_latency", cyc - e.t, 32'd1);
          end
          last_a = data_a;
        end else check("a_hold", {24'b0, data_a}, {24'b0, last_a});
        if (valid_b) begin
          if (qb.size() == 0) check("b_unexpected_valid", 32'd1, 32'd0);
          else begin
            e = qb.pop_front();
            check("b_data", data_b, e.data);
            check("b_latency", cyc - e.t, 32'd2);
          end
          last_b = data_b;
        end else check("b_hold", data_b, last_b);
      end
    end
  end

  task automatic op(input logic we, input logic [3:0] wa, input logic [3:0] be,
                    input logic [31:0] wd, input logic re, input logic [3:0] ra,
                    input logic [7:0] ea, input logic [31:0] eb,
                    input logic pa, input logic pb);
    @(negedge clk);
    wr_en   = we;
    wr_addr = wa;
    wr_be   = be;
    wr_data = wd;
    rd_en   = re;
    rd_addr = ra;
    if (re && pa) qa.push_back('{data: {24'b0, ea}, t: cyc});
    if (re && pb) qb.push_back('{data: eb, t: cyc});
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
    op(1'b1, a, be, d, 1'b0, 4'd0, 8'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] ea, input logic [31:0] eb);
    op(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, a, ea, eb, 1'b1, 1'b1);
  endtask

  task automatic nop();
    op(1'b0, 4'd0, 4'd0, 32'd0, 1'b0, 4'd0, 8'd0, 32'd0, 1'b0, 1'b0);
  endtask

  // Called on the negedge where rst was just released; counts busy cycles,
  // optionally hammering both ports to show they are ignored during the sweep.
  task automatic count_busy(input int expn, input bit noisy);
    int na = 0;
    int nb = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy_a && !busy_b) break;
      na += int'(busy_a);
      nb += int'(busy_b);
      if (noisy) begin
        wr_en = 1'b1; wr_addr = 4'(i); wr_be = 4'hF; wr_data = 32'hFFFF_FFFF;
        rd_en = 1'b1; rd_addr = 4'(i);
      end
      @(negedge clk);
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    check("a_busy_cycles", na, expn);
    check("b_busy_cycles", nb, expn);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_be = '0; wr_data = '0;

    // Reset, clear sweep, then every word reads back as zero.
    @(negedge clk);
    rst = 1'b0;
    check("a_busy_after_rst", {31'b0, busy_a}, 32'd1);
    count_busy(16, 1'b1);
    for (int i = 0; i < 16; i++) rd(4'(i), 8'h00, 32'h0);
    nop();

    // Basic write/read, then simultaneous write and read of different addresses.
    wr(4'd3, 4'hF, 32'h0000_00A5);
    rd(4'd3, 8'hA5, 32'h0000_00A5);
    op(1'b1, 4'd2, 4'hF, 32'h0000_0042, 1'b1, 4'd3, 8'hA5, 32'h0000_00A5, 1'b1, 1'b1);
    nop();

    // Byte-lane enables and an all-zero enable.
    wr(4'd5, 4'hF, 32'h1122_3344);
    wr(4'd5, 4'b0101, 32'hFFFF_FFFF);
    rd(4'd5, 8'hFF, 32'h11FF_33FF);
    wr(4'd6, 4'hF, 32'h0000_005A);
    wr(4'd6, 4'h0, 32'h0000_0000);
    rd(4'd6, 8'h5A, 32'h0000_005A);
    nop();

    // Same-address read during write: old data on a, merged new data on b.
    wr(4'd7, 4'hF, 32'h0000_000F);
    op(1'b1, 4'd7, 4'hF, 32'h0000_00F0, 1'b1, 4'd7, 8'h0F, 32'h0000_00F0, 1'b1, 1'b1);
    rd(4'd7, 8'hF0, 32'h0000_00F0);
    wr(4'd9, 4'hF, 32'hAABB_CCDD);
    op(1'b1, 4'd9, 4'b0101, 32'h1122_3344, 1'b1, 4'd9, 8'hDD, 32'hAA22_CC44, 1'b1, 1'b1);
    rd(4'd9, 8'h44, 32'hAA22_CC44);
    nop();

    // Back-to-back reads across the address extremes.
    wr(4'd0, 4'hF, 32'hCAFE_0010);
    wr(4'd15, 4'hF, 32'hCAFE_001F);
    wr(4'd1, 4'hF, 32'hCAFE_0011);
    wr(4'd14, 4'hF, 32'hCAFE_001E);
    rd(4'd0, 8'h10, 32'hCAFE_0010);
    rd(4'd15, 8'h1F, 32'hCAFE_001F);
    rd(4'd1, 8'h11, 32'hCAFE_0011);
    rd(4'd14, 8'h1E, 32'hCAFE_001E);
    rd(4'd2, 8'h42, 32'h0000_0042);
    repeat (3) nop();

    // Reset mid-sweep with the clear pointer at 8 restarts the full sweep.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("a_busy_mid_sweep", {31'b0, busy_a}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    count_busy(16, 1'b1);
    rd(4'd3, 8'h00, 32'h0);
    nop();

    // Reset during a write/read stream: b's last read is still in flight and is dropped.
    wr(4'd3, 4'hF, 32'h7777_7777);
    wr(4'd5, 4'hF, 32'h5555_5555);
    rd(4'd3, 8'h77, 32'h7777_7777);
    op(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd5, 8'h55, 32'h5555_5555, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1; rd_en = 1'b1; rd_addr = 4'd5; wr_en = 1'b1; wr_addr = 4'd5;
    @(negedge clk);
    rst = 1'b0;
    count_busy(16, 1'b0);
    rd(4'd3, 8'h00, 32'h0);
    rd(4'd5, 8'h00, 32'h0);
    rd(4'd7, 8'h00, 32'h0);
    repeat (5) nop();

    check("a_queue_drained", qa.size(), 32'd0);
    check("b_queue_drained", qb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
